cla_seq_arbiter: RTL and testbench

Iterative wide-operand adder/subtractor controller that shares one 4-bit carry-lookahead adder cell between two requesters. It arbitrates round-robin between the requesters and captures the winner's WIDTH-bit operands. It then sequences the 4-bit cell nibble by nibble, least significant first, with a registered ripple carry. It returns the sum, carry-out and signed overflow with a one-cycle done pulse. It sits between the two requesting datapath clients and the single instantiated 4-bit CLA cell (ports sum, c_out, a, b, c_in).

---
 rtl/cla_seq_arbiter_if.sv | 32 +++
 rtl/cla_seq_arbiter.sv | 132 +++++++++++++
 tb/tb_cla_seq_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cla_seq_arbiter_if.sv
// Request/grant/result bundle between the two datapath clients and the
// shared-CLA arbiter.
interface cla_seq_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             sub0;
  logic             sub1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output req0, req1, a0, b0, a1, b1, sub0, sub1,
    input  gnt0, gnt1, busy, done, done_id, result, cout, ovf
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, sub0, sub1,
    output gnt0, gnt1, busy, done, done_id, result, cout, ovf
  );
endinterface

// File: rtl/cla_seq_arbiter.sv
// Round-robin arbiter that time-shares one 4-bit CLA cell to perform
// WIDTH-bit add/subtract, one nibble per cycle with a registered carry.
module cla4_cell (
  output logic [3:0] sum,
  output logic       c_out,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);
  assign sum   = p ^ c[3:0];
  assign c_out = c[4];
endmodule

module cla_seq_arbiter #(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  cla_seq_arbiter_if.slave  bus
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB   = WIDTH - 1;

  // state | meaning
  // IDLE  | waiting for a request; arbitrates and captures operands
  // CALC  | one nibble per cycle through the shared CLA cell
  // DONE  | result registers valid, done pulse high
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nx;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             id;
  logic             last_gnt;
  logic             capture, winner, sub_w, last_nib;
  logic [IDX_W+1:0] base;
  logic [3:0]       nib_sum;
  logic             nib_cout;

  assign base     = {idx, 2'b00};
  assign last_nib = (idx == IDX_W'(NIB - 1));
  assign bus.busy = (state != IDLE);

  cla4_cell u_cell (
    .sum   (nib_sum),
    .c_out (nib_cout),
    .a     (a_reg[base +: 4]),
    .b     (b_reg[base +: 4]),
    .c_in  (carry)
  );

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    // Tie goes to whoever was not granted last.
    winner   = (bus.req0 & bus.req1) ? ~last_gnt : bus.req1;
    sub_w    = winner ? bus.sub1 : bus.sub0;
    acc_nx   = acc;
    acc_nx[base +: 4] = nib_sum;
    case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          capture  = 1'b1;
          state_nx = CALC;
        end
      end
      CALC:    if (last_nib) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      id          <= 1'b0;
      last_gnt    <= 1'b1;
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.done    <= 1'b0;
      bus.done_id <= 1'b0;
      bus.result  <= '0;
      bus.cout    <= 1'b0;
      bus.ovf     <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.gnt0 <= capture & ~winner;
      bus.gnt1 <= capture & winner;
      bus.done <= 1'b0;
      if (capture) begin
        a_reg    <= winner ? bus.a1 : bus.a0;
        b_reg    <= (winner ? bus.b1 : bus.b0) ^ {WIDTH{sub_w}};
        carry    <= sub_w;
        idx      <= '0;
        id       <= winner;
        last_gnt <= winner;
      end else if (state == CALC) begin
        acc   <= acc_nx;
        carry <= nib_cout;
        idx   <= idx + 1'b1;
        // Results are loaded with the last nibble so done lands in DONE.
        if (last_nib) begin
          bus.done    <= 1'b1;
          bus.done_id <= id;
          bus.result  <= acc_nx;
          bus.cout    <= nib_cout;
          bus.ovf     <= (a_reg[MSB] == b_reg[MSB]) & (nib_sum[3] != a_reg[MSB]);
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_seq_arbiter.sv
// Directed bench for cla_seq_arbiter: single ops, borrow/ripple corners,
// round-robin alternation, requests while busy, and mid-operation reset.
module tb_cla_seq_arbiter;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;

  cla_seq_arbiter_if #(.WIDTH(16)) bus ();

  cla_seq_arbiter #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!bus.done && t < 20) begin
      step();
      t++;
    end
    check({tag, "_done_seen"}, 32'(t < 20), 32'd1);
  endtask

  task automatic run_op(input string tag, input bit rid, input logic [15:0] a,
                        input logic [15:0] b, input bit sub, input logic [15:0] exp_res,
                        input bit exp_cout, input bit exp_ovf);
    int t = 0;
    if (rid) begin
      bus.a1 = a; bus.b1 = b; bus.sub1 = sub; bus.req1 = 1'b1;
    end else begin
      bus.a0 = a; bus.b0 = b; bus.sub0 = sub; bus.req0 = 1'b1;
    end
    step();
    check({tag, "_gnt0"}, 32'(bus.gnt0), 32'(!rid));
    check({tag, "_gnt1"}, 32'(bus.gnt1), 32'(rid));
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    while (!bus.done && t < 20) begin
      step();
      t++;
    end
    check({tag, "_latency"}, 32'(t), 32'd4);
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    check({tag, "_done_id"}, 32'(bus.done_id), 32'(rid));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
    step();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_result_hold"}, 32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    int gid [4];
    int did [4];
    int gcyc [4];
    int g0_cyc;
    int t;
    int seen;

    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.sub0 = 1'b0; bus.sub1 = 1'b0;
    #12;
    check("rst_gnt0", 32'(bus.gnt0), 32'd0);
    check("rst_gnt1", 32'(bus.gnt1), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_done_id", 32'(bus.done_id), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ripple", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_borrow", 1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_noborrow", 1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Both held: last grant was requester 1, so 0 leads.
    bus.a0 = 16'h0100; bus.b0 = 16'h0001; bus.sub0 = 1'b0;
    bus.a1 = 16'h0200; bus.b1 = 16'h0001; bus.sub1 = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      while (!(bus.gnt0 | bus.gnt1) && t < 20) begin
        step();
        t++;
      end
      check("alt_gnt_seen", 32'(t < 20), 32'd1);
      gid[g]  = int'(bus.gnt1);
      gcyc[g] = cyc_cnt;
      wait_done("alt");
      did[g] = int'(bus.done_id);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("alt_last_result", 32'(bus.result), 32'h01FF);
    check("alt_last_cout", 32'(bus.cout), 32'd1);
    check("alt_gid0", 32'(gid[0]), 32'd0);
    check("alt_gid1", 32'(gid[1]), 32'd1);
    check("alt_gid2", 32'(gid[2]), 32'd0);
    check("alt_gid3", 32'(gid[3]), 32'd1);
    check("alt_did0", 32'(did[0]), 32'd0);
    check("alt_did1", 32'(did[1]), 32'd1);
    check("alt_did2", 32'(did[2]), 32'd0);
    check("alt_did3", 32'(did[3]), 32'd1);
    for (int g = 1; g < 4; g++) check("alt_gap", 32'(gcyc[g] - gcyc[g-1]), 32'd6);
    step();
    step();
    check("alt_idle_busy", 32'(bus.busy), 32'd0);
    check("alt_idle_gnt", 32'(bus.gnt0 | bus.gnt1), 32'd0);

    // Request from 1 arriving while 0's op is in flight.
    bus.a0 = 16'h1234; bus.b0 = 16'h1111; bus.sub0 = 1'b0; bus.req0 = 1'b1;
    step();
    check("busyreq_gnt0", 32'(bus.gnt0), 32'd1);
    g0_cyc = cyc_cnt;
    bus.req0 = 1'b0;
    step();
    bus.a1 = 16'h0005; bus.b1 = 16'h0003; bus.sub1 = 1'b1; bus.req1 = 1'b1;
    seen = 0;
    t = 0;
    while (!bus.done && t < 20) begin
      step();
      t++;
      if (bus.gnt1) seen++;
    end
    check("busyreq_done_seen", 32'(t < 20), 32'd1);
    check("busyreq_no_gnt1", 32'(seen), 32'd0);
    check("busyreq_result0", 32'(bus.result), 32'h2345);
    check("busyreq_done_id0", 32'(bus.done_id), 32'd0);
    step();
    check("busyreq_idle_gnt1", 32'(bus.gnt1), 32'd0);
    check("busyreq_idle_busy", 32'(bus.busy), 32'd0);
    step();
    check("busyreq_gnt1", 32'(bus.gnt1), 32'd1);
    check("busyreq_gap", 32'(cyc_cnt - g0_cyc), 32'd6);
    bus.req1 = 1'b0;
    wait_done("busyreq1");
    check("busyreq_result1", 32'(bus.result), 32'h0002);
    check("busyreq_done_id1", 32'(bus.done_id), 32'd1);
    step();

    // Reset in the middle of CALC.
    bus.a0 = 16'h1234; bus.b0 = 16'h1111; bus.sub0 = 1'b0; bus.req0 = 1'b1;
    step();
    bus.req0 = 1'b0;
    step();
    check("midrst_busy_before", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_cout", 32'(bus.cout), 32'd0);
    check("midrst_done_id", 32'(bus.done_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    check("midrst_idle", 32'(bus.busy), 32'd0);

    // Pointer back at 1 after reset: requester 0 takes the first tie.
    bus.a1 = 16'h0001; bus.b1 = 16'h0001; bus.sub1 = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step();
    check("tie_after_rst_gnt0", 32'(bus.gnt0), 32'd1);
    check("tie_after_rst_gnt1", 32'(bus.gnt1), 32'd0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_done("tie_after_rst");
    check("tie_after_rst_result", 32'(bus.result), 32'h2345);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
